// File: rtl/exc_ctrl.sv
// exc_ctrl: exception and system-register controller at the memory-stage
// output of the br32 pipeline.
//
// It handles udf, scall, eret, mtsr and the external interrupt for the
// instruction leaving the memory stage. It owns the four system registers
// (EPC, CAUSE, STATUS, EVEC). A taken event runs a fixed two-cycle
// sequence: FLUSH, then REDIR with the fetch target. After that the block
// is back in RUN.
//
// Ports
//   clk, rst            pipeline clock, synchronous active-high reset
//   mo_pc, mo_nextpc    PC and sequential successor of the mem-stage instr
//   mo_op3, mo_rd       mtsr source value and target (rd[1:0] = SR index)
//   mo_mtsr/scall/eret/udf  instruction-class flags
//   mo_bubble           empty slot, flags ignored
//   irq                 level-sensitive external interrupt
//   sr_raddr, sr_rdata  mfsr read port (combinational, with mtsr forward)
//   flush, stall        pipeline kill / front-end hold
//   redirect, redirect_pc  fetch redirect strobe and registered target
module exc_ctrl #(
  parameter logic [31:0] EVEC_RESET = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mo_pc,
  input  logic [31:0] mo_nextpc,
  input  logic [31:0] mo_op3,
  input  logic [4:0]  mo_rd,
  input  logic        mo_mtsr,
  input  logic        mo_scall,
  input  logic        mo_eret,
  input  logic        mo_udf,
  input  logic        mo_bubble,
  input  logic        irq,
  input  logic [1:0]  sr_raddr,
  output logic [31:0] sr_rdata,
  output logic        flush,
  output logic        stall,
  output logic        redirect,
  output logic [31:0] redirect_pc
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_FLUSH = 2'd1;
  localparam logic [1:0] S_REDIR = 2'd2;

  localparam logic [1:0] SR_EPC    = 2'd0;
  localparam logic [1:0] SR_CAUSE  = 2'd1;
  localparam logic [1:0] SR_STATUS = 2'd2;
  localparam logic [1:0] SR_EVEC   = 2'd3;

  localparam logic [31:0] CAUSE_UDF   = 32'd1;
  localparam logic [31:0] CAUSE_SCALL = 32'd2;
  localparam logic [31:0] CAUSE_IRQ   = 32'd3;

  logic [1:0]  state;

  // System registers. STATUS keeps only IE/PIE, EVEC only its word bits.
  logic [31:0] epc;
  logic [31:0] cause;
  logic        ie;
  logic        pie;
  logic [29:0] evec_hi;

  // Event decode
  logic        valid;
  logic        take_udf;
  logic        take_scall;
  logic        take_eret;
  logic        take_irq;
  logic        take_trap;
  logic        take_any;
  logic        mtsr_commit;
  logic [1:0]  mtsr_idx;
  logic [31:0] mtsr_val;
  logic [31:0] trap_epc;
  logic [31:0] trap_cause;
  logic [29:0] evec_eff;
  logic [31:0] sr_cur;

  assign valid      = (state == S_RUN) && !mo_bubble;
  assign take_udf   = valid && mo_udf;
  assign take_scall = valid && mo_scall && !mo_udf;
  assign take_eret  = valid && mo_eret && !mo_udf && !mo_scall;
  // irq is gated by IE as it was before any mtsr in this same slot.
  assign take_irq   = valid && irq && ie && !mo_udf && !mo_scall && !mo_eret;
  assign take_trap  = take_udf || take_scall || take_irq;
  assign take_any   = take_trap || take_eret;

  // mtsr survives eret and irq, but not a synchronous trap in its own slot.
  assign mtsr_commit = valid && mo_mtsr && !mo_udf && !mo_scall;
  assign mtsr_idx    = mo_rd[1:0];

  // Value as it will be stored, so reads of the forward match reads of
  // the register one cycle later.
  always_comb begin
    mtsr_val = mo_op3;
    case (mtsr_idx)
      SR_STATUS: mtsr_val = {30'd0, mo_op3[1:0]};
      SR_EVEC:   mtsr_val = {mo_op3[31:2], 2'b00};
      default:   mtsr_val = mo_op3;
    endcase
  end

  always_comb begin
    trap_epc   = mo_nextpc;
    trap_cause = CAUSE_IRQ;
    if (take_udf) begin
      trap_epc   = mo_pc;
      trap_cause = CAUSE_UDF;
    end else if (take_scall) begin
      trap_epc   = mo_nextpc;
      trap_cause = CAUSE_SCALL;
    end
  end

  // An mtsr to EVEC commits ahead of a coincident irq, so the trap vectors
  // through the freshly written value.
  assign evec_eff = (mtsr_commit && mtsr_idx == SR_EVEC) ? mo_op3[31:2] : evec_hi;

  always_comb begin
    sr_cur = epc;
    case (sr_raddr)
      SR_EPC:    sr_cur = epc;
      SR_CAUSE:  sr_cur = cause;
      SR_STATUS: sr_cur = {30'd0, pie, ie};
      SR_EVEC:   sr_cur = {evec_hi, 2'b00};
      default:   sr_cur = epc;
    endcase
  end

  assign sr_rdata = (mtsr_commit && mtsr_idx == sr_raddr) ? mtsr_val : sr_cur;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_RUN;
      epc         <= 32'd0;
      cause       <= 32'd0;
      ie          <= 1'b0;
      pie         <= 1'b0;
      evec_hi     <= EVEC_RESET[31:2];
      redirect_pc <= 32'd0;
    end else begin
      case (state)
        S_RUN:   if (take_any) state <= S_FLUSH;
        S_FLUSH: state <= S_REDIR;
        default: state <= S_RUN;
      endcase

      if (mtsr_commit) begin
        case (mtsr_idx)
          SR_EPC:    epc     <= mo_op3;
          SR_CAUSE:  cause   <= mo_op3;
          SR_STATUS: {pie, ie} <= mo_op3[1:0];
          default:   evec_hi <= mo_op3[31:2];
        endcase
      end

      // Later assignments override the mtsr write above.
      if (take_trap) begin
        epc         <= trap_epc;
        cause       <= trap_cause;
        pie         <= ie;
        ie          <= 1'b0;
        redirect_pc <= {evec_eff, 2'b00};
      end

      // eret returns through the pre-write EPC and restores IE from the
      // pre-write PIE; a coincident mtsr to STATUS still sets PIE.
      if (take_eret) begin
        ie          <= pie;
        redirect_pc <= epc;
      end
    end
  end

  assign flush    = (state == S_FLUSH);
  assign redirect = (state == S_REDIR);
  assign stall    = (state == S_FLUSH) || (state == S_REDIR);

endmodule

// File: tb/tb_exc_ctrl.sv
// Bench for exc_ctrl: directed scenarios followed by randomized traffic,
// every cycle compared against a behavioural model of the register file
// and the trap sequence.
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mo_pc, mo_nextpc, mo_op3;
  logic [4:0]  mo_rd;
  logic        mo_mtsr, mo_scall, mo_eret, mo_udf, mo_bubble, irq;
  logic [1:0]  sr_raddr;
  logic [31:0] sr_rdata;
  logic        flush, stall, redirect;
  logic [31:0] redirect_pc;

  int checks = 0;
  int errors = 0;

  exc_ctrl #(.EVEC_RESET(32'h0000_0100)) dut (
    .clk(clk), .rst(rst),
    .mo_pc(mo_pc), .mo_nextpc(mo_nextpc), .mo_op3(mo_op3), .mo_rd(mo_rd),
    .mo_mtsr(mo_mtsr), .mo_scall(mo_scall), .mo_eret(mo_eret),
    .mo_udf(mo_udf), .mo_bubble(mo_bubble), .irq(irq),
    .sr_raddr(sr_raddr), .sr_rdata(sr_rdata),
    .flush(flush), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  // ---------------- model ----------------
  logic [31:0] m_sr [4];
  int          m_ph;      // cycles into the trap sequence: 0 run, 1 flush, 2 redirect
  logic [31:0] m_rpc;

  function automatic logic [31:0] stored(input logic [1:0] idx, input logic [31:0] v);
    if (idx == 2'd2) return v & 32'h3;
    if (idx == 2'd3) return v & 32'hFFFF_FFFC;
    return v;
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] idx);
    if (m_ph == 0 && !mo_bubble && mo_mtsr && !mo_udf && !mo_scall && mo_rd[1:0] == idx)
      return stored(idx, mo_op3);
    return m_sr[idx];
  endfunction

  task automatic m_reset();
    m_sr[0] = 0; m_sr[1] = 0; m_sr[2] = 0; m_sr[3] = 32'h100;
    m_ph = 0; m_rpc = 0;
  endtask

  task automatic m_trap(input logic [31:0] e, input logic [31:0] c, input logic old_ie);
    m_sr[0] = e;
    m_sr[1] = c;
    m_sr[2] = old_ie ? 32'h2 : 32'h0;
    m_rpc   = m_sr[3];
    m_ph    = 1;
  endtask

  always @(posedge clk) begin
    logic old_ie, old_pie;
    logic [31:0] old_epc;
    if (rst) m_reset();
    else if (m_ph == 1) m_ph = 2;
    else if (m_ph == 2) m_ph = 0;
    else if (!mo_bubble) begin
      old_ie  = m_sr[2][0];
      old_pie = m_sr[2][1];
      old_epc = m_sr[0];
      if (mo_udf) m_trap(mo_pc, 1, old_ie);
      else if (mo_scall) m_trap(mo_nextpc, 2, old_ie);
      else begin
        if (mo_mtsr) m_sr[mo_rd[1:0]] = stored(mo_rd[1:0], mo_op3);
        if (mo_eret) begin
          m_rpc = old_epc;
          m_sr[2][0] = old_pie;
          m_ph = 1;
        end else if (irq && old_ie) m_trap(mo_nextpc, 3, old_ie);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("flush",    {31'd0, flush},    {31'd0, m_ph == 1});
      chk("stall",    {31'd0, stall},    {31'd0, m_ph != 0});
      chk("redirect", {31'd0, redirect}, {31'd0, m_ph == 2});
      if (m_ph == 2) chk("redirect_pc", redirect_pc, m_rpc);
      chk("sr_rdata", sr_rdata, m_read(sr_raddr));
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    mo_pc = 0; mo_nextpc = 0; mo_op3 = 0; mo_rd = 0;
    mo_mtsr = 0; mo_scall = 0; mo_eret = 0; mo_udf = 0; mo_bubble = 0; irq = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic rd_chk(input string name, input logic [1:0] idx, input logic [31:0] exp);
    sr_raddr = idx; #1;
    chk(name, sr_rdata, exp);
  endtask

  task automatic mtsr(input logic [1:0] idx, input logic [31:0] v);
    idle(); mo_mtsr = 1; mo_rd = {3'd0, idx}; mo_op3 = v; tick(); idle();
  endtask

  initial begin
    idle(); rst = 1; sr_raddr = 0;
    tick(); tick(); rst = 0;

    // reset state
    chk("rst_flush", {31'd0, flush}, 0);
    chk("rst_stall", {31'd0, stall}, 0);
    chk("rst_redirect", {31'd0, redirect}, 0);
    chk("rst_rpc", redirect_pc, 0);
    rd_chk("rst_evec", 3, 32'h100);
    rd_chk("rst_status", 2, 0);

    // mtsr EVEC with forward, then registered read
    mo_mtsr = 1; mo_rd = 5'd3; mo_op3 = 32'h0000_2003; sr_raddr = 3; #1;
    chk("evec_fwd", sr_rdata, 32'h2000);
    tick(); idle();
    rd_chk("evec_reg", 3, 32'h2000);
    mtsr(3, 32'h100);

    // scall
    mo_scall = 1; mo_pc = 32'h40; mo_nextpc = 32'h44; tick(); idle();
    chk("scall_flush", {31'd0, flush}, 1);
    tick();
    chk("scall_redir", {31'd0, redirect}, 1);
    chk("scall_rpc", redirect_pc, 32'h100);
    tick();
    rd_chk("scall_epc", 0, 32'h44);
    rd_chk("scall_cause", 1, 2);
    rd_chk("scall_status", 2, 0);
    chk("model_epc", m_sr[0], 32'h44);

    // udf beats irq
    mtsr(2, 1);
    mo_udf = 1; mo_pc = 32'h80; mo_nextpc = 32'h84; irq = 1; tick(); idle();
    tick(); tick();
    rd_chk("udf_cause", 1, 1);
    rd_chk("udf_epc", 0, 32'h80);
    rd_chk("udf_status", 2, 2);

    // eret with irq held
    mtsr(0, 32'h44);
    mo_eret = 1; irq = 1; tick();
    mo_eret = 0; mo_nextpc = 32'h90;
    chk("eret_flush", {31'd0, flush}, 1);
    tick();
    chk("eret_rpc", redirect_pc, 32'h44);
    tick();
    rd_chk("eret_status", 2, 3);
    chk("eret_run", {31'd0, stall}, 0);
    tick();
    chk("irq_flush", {31'd0, flush}, 1);
    tick(); tick(); irq = 0;
    rd_chk("irq_cause", 1, 3);
    rd_chk("irq_epc", 0, 32'h90);

    // irq masked for 10 slots, then enabled by mtsr
    irq = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("masked_noflush", {31'd0, flush}, 0);
    end
    mo_mtsr = 1; mo_rd = 2; mo_op3 = 1; tick();
    mo_mtsr = 0;
    chk("mtsr_noflush", {31'd0, flush}, 0);
    tick();
    chk("enabled_flush", {31'd0, flush}, 1);
    idle(); tick(); tick();

    // rst during FLUSH
    mtsr(3, 32'h400);
    mo_scall = 1; tick(); idle();
    chk("pre_rst_flush", {31'd0, flush}, 1);
    rst = 1; tick(); rst = 0;
    for (int i = 0; i < 3; i++) begin
      chk("rst_noredir", {31'd0, redirect | flush | stall}, 0);
      tick();
    end
    chk("rst2_rpc", redirect_pc, 0);
    rd_chk("rst2_evec", 3, 32'h100);
    rd_chk("rst2_epc", 0, 0);
    rd_chk("rst2_cause", 1, 0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rst       = ($urandom_range(199) == 0);
      mo_pc     = $urandom & 32'hFFFF_FFFC;
      mo_nextpc = mo_pc + 4;
      mo_op3    = $urandom;
      mo_rd     = 5'($urandom);
      mo_bubble = ($urandom_range(3) == 0);
      mo_mtsr   = ($urandom_range(3) == 0);
      mo_udf    = ($urandom_range(15) == 0);
      mo_scall  = ($urandom_range(15) == 0);
      mo_eret   = ($urandom_range(11) == 0);
      irq       = ($urandom_range(2) == 0);
      sr_raddr  = 2'($urandom);
      tick();
    end
    rst = 0; idle(); tick(); tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
